// File: rtl/mem_readback_check.sv
// Post-boot read-back verifier: walks the ROM image and the RAM load region, compares word pairs.
// Build option MEMCHK_STOP_ON_FAIL_EN ends the scan at the first mismatching word.

`ifndef PC_START_ADDR
`define PC_START_ADDR 32'h0000_1000
`endif

`ifndef MemRW_L
`define MemRW_L 1'b0
`endif

module mem_readback_check #(
    parameter logic [31:0] ROM_BEGIN  = 32'h0000_0000,
    parameter logic [31:0] ROM_END    = 32'h0000_0200,
    parameter logic [31:0] RAM_BEGIN  = `PC_START_ADDR,
    parameter int          RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] ROM_Addr,
    input  logic [31:0] ROM_Data,
    output logic [31:0] RAM_Addr,
    input  logic [31:0] RAM_Data,
    output logic        MemRW,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] err_addr,
    output logic [31:0] err_exp,
    output logic [31:0] err_got
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // ADDR  | ROM/RAM addresses presented for one cycle
    // WAIT  | extra read latency (RD_LATENCY-1 cycles)
    // CMP   | compare data, log error, advance or finish
    // DONE  | result held until the next start

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CMP,
        DONE
    } state_t;

    localparam logic [31:0] WORD_COUNT  = (ROM_END - ROM_BEGIN) >> 2;
    localparam logic [31:0] LAST_WORD   = WORD_COUNT - 32'd1;
    localparam int          WAIT_CYCLES = (RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0;
    localparam logic [1:0]  WAIT_INIT   = 2'(WAIT_CYCLES);

`ifdef MEMCHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t      state;
    logic [31:0] word_cnt;
    logic [1:0]  wait_cnt;
    logic        mismatch;
    logic        first_err;
    logic        last_word;
    logic [15:0] err_count_nxt;

    assign MemRW     = `MemRW_L;
    assign mismatch  = (ROM_Data != RAM_Data);
    assign first_err = mismatch && (err_count == 16'd0);
    assign last_word = (word_cnt == LAST_WORD);

    always_comb begin
        err_count_nxt = err_count;
        if (mismatch && (err_count != 16'hFFFF)) begin
            err_count_nxt = err_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ROM_Addr  <= ROM_BEGIN;
            RAM_Addr  <= RAM_BEGIN;
            word_cnt  <= 32'd0;
            wait_cnt  <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 16'd0;
            err_addr  <= 32'd0;
            err_exp   <= 32'd0;
            err_got   <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ROM_Addr  <= ROM_BEGIN;
                        RAM_Addr  <= RAM_BEGIN;
                        word_cnt  <= 32'd0;
                        err_count <= 16'd0;
                        err_addr  <= 32'd0;
                        err_exp   <= 32'd0;
                        err_got   <= 32'd0;
                        // An empty image is trivially clean.
                        if (WORD_COUNT == 32'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= ADDR;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end

                ADDR: begin
                    if (RD_LATENCY > 1) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= CMP;
                    end
                end

                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= CMP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                CMP: begin
                    err_count <= err_count_nxt;
                    if (first_err) begin
                        err_addr <= RAM_Addr;
                        err_exp  <= ROM_Data;
                        err_got  <= RAM_Data;
                    end
                    if (last_word || (STOP_ON_FAIL && mismatch)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count_nxt == 16'd0);
                    end else begin
                        ROM_Addr <= ROM_Addr + 32'd4;
                        RAM_Addr <= RAM_Addr + 32'd4;
                        word_cnt <= word_cnt + 32'd1;
                        state    <= ADDR;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_readback_check.sv
// Bench for mem_readback_check: table vectors, random corruption against a scan model, corner sequences.

module tb_mem_readback_check;

    localparam logic [31:0] RAM_BASE = 32'h0001_0000;
    localparam int          NWORDS   = 128;

`ifdef MEMCHK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0, start0 = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] rom_mem [NWORDS];
    logic [31:0] ram_mem [NWORDS];

    logic [31:0] rom_addr1, ram_addr1, rom_data1, ram_data1;
    logic        memrw1, busy1, done1, pass1;
    logic [15:0] cnt1;
    logic [31:0] eaddr1, eexp1, egot1;

    logic [31:0] rom_addr3, ram_addr3, rom_data3, ram_data3;
    logic        memrw3, busy3, done3, pass3;
    logic [15:0] cnt3;
    logic [31:0] eaddr3, eexp3, egot3;

    logic [31:0] rom_addr0, ram_addr0;
    logic        memrw0, busy0, done0, pass0;
    logic [15:0] cnt0;
    logic [31:0] eaddr0, eexp0, egot0;

    int errors = 0;
    int checks = 0;

    mem_readback_check #(.ROM_BEGIN(32'h0), .ROM_END(32'h200), .RAM_BEGIN(RAM_BASE), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .ROM_Addr(rom_addr1), .ROM_Data(rom_data1), .RAM_Addr(ram_addr1), .RAM_Data(ram_data1),
        .MemRW(memrw1), .busy(busy1), .done(done1), .pass(pass1), .err_count(cnt1),
        .err_addr(eaddr1), .err_exp(eexp1), .err_got(egot1));

    mem_readback_check #(.ROM_BEGIN(32'h0), .ROM_END(32'h200), .RAM_BEGIN(RAM_BASE), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .ROM_Addr(rom_addr3), .ROM_Data(rom_data3), .RAM_Addr(ram_addr3), .RAM_Data(ram_data3),
        .MemRW(memrw3), .busy(busy3), .done(done3), .pass(pass3), .err_count(cnt3),
        .err_addr(eaddr3), .err_exp(eexp3), .err_got(egot3));

    mem_readback_check #(.ROM_BEGIN(32'h100), .ROM_END(32'h100), .RAM_BEGIN(RAM_BASE), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .ROM_Addr(rom_addr0), .ROM_Data(32'h0), .RAM_Addr(ram_addr0), .RAM_Data(32'h0),
        .MemRW(memrw0), .busy(busy0), .done(done0), .pass(pass0), .err_count(cnt0),
        .err_addr(eaddr0), .err_exp(eexp0), .err_got(egot0));

    function automatic logic [31:0] mem_rd(input bit is_ram, input logic [31:0] addr);
        logic [31:0] off;
        off = is_ram ? (addr - RAM_BASE) >> 2 : addr >> 2;
        if (off >= NWORDS) return 32'h0;
        return is_ram ? ram_mem[off] : rom_mem[off];
    endfunction

    // Synchronous memories: one register stage for dut1, three for dut3.
    logic [31:0] rom_p3 [3];
    logic [31:0] ram_p3 [3];
    always @(posedge clk) begin
        rom_data1 <= mem_rd(1'b0, rom_addr1);
        ram_data1 <= mem_rd(1'b1, ram_addr1);
        rom_p3[0] <= mem_rd(1'b0, rom_addr3);
        ram_p3[0] <= mem_rd(1'b1, ram_addr3);
        rom_p3[1] <= rom_p3[0];
        ram_p3[1] <= ram_p3[0];
        rom_p3[2] <= rom_p3[1];
        ram_p3[2] <= ram_p3[1];
    end
    assign rom_data3 = rom_p3[2];
    assign ram_data3 = ram_p3[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample(input int sel, output logic d, output logic b, output logic p,
                          output logic [15:0] c, output logic [31:0] a, output logic [31:0] e,
                          output logic [31:0] g);
        if (sel == 3) begin
            d = done3; b = busy3; p = pass3; c = cnt3; a = eaddr3; e = eexp3; g = egot3;
        end else begin
            d = done1; b = busy1; p = pass1; c = cnt1; a = eaddr1; e = eexp1; g = egot1;
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 3) start3 = v;
        else start1 = v;
    endtask

    // Scan model: walks the two images as plain arrays.
    task automatic model(input int lat, output int cyc, output logic p, output logic [15:0] cnt,
                         output logic [31:0] a, output logic [31:0] e, output logic [31:0] g);
        int first;
        int n;
        first = -1;
        n = 0;
        for (int i = 0; i < NWORDS; i++) begin
            if (rom_mem[i] != ram_mem[i]) begin
                if (first < 0) first = i;
                n++;
                if (STOP) break;
            end
        end
        cnt = 16'(n);
        p = (n == 0);
        cyc = (STOP && first >= 0) ? (first + 1) * (lat + 1) : NWORDS * (lat + 1);
        a = (first >= 0) ? RAM_BASE + 32'(first * 4) : 32'h0;
        e = (first >= 0) ? rom_mem[first] : 32'h0;
        g = (first >= 0) ? ram_mem[first] : 32'h0;
    endtask

    task automatic run_scan(input string tag, input int sel, input bit hold,
                            input int exp_cyc, input logic exp_p, input logic [15:0] exp_c,
                            input logic [31:0] exp_a, input logic [31:0] exp_e, input logic [31:0] exp_g);
        logic d, b, p;
        logic [15:0] c;
        logic [31:0] a, e, g;
        int cyc;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(sel, 1'b0);
        sample(sel, d, b, p, c, a, e, g);
        chk({tag, " busy_at_start"}, 32'(b), 32'd1);
        chk({tag, " done_cleared"}, 32'(d), 32'd0);
        chk({tag, " cnt_cleared"}, 32'(c), 32'd0);
        cyc = 0;
        while (!d && cyc < 2000) begin
            if (hold && cyc == 100) set_start(sel, 1'b0);
            @(posedge clk);
            #1;
            cyc++;
            sample(sel, d, b, p, c, a, e, g);
        end
        set_start(sel, 1'b0);
        chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " busy_low"}, 32'(b), 32'd0);
        chk({tag, " pass"}, 32'(p), 32'(exp_p));
        chk({tag, " err_count"}, 32'(c), 32'(exp_c));
        chk({tag, " err_addr"}, a, exp_a);
        chk({tag, " err_exp"}, e, exp_e);
        chk({tag, " err_got"}, g, exp_g);
    endtask

    task automatic run_model_scan(input string tag, input int sel, input bit hold);
        int cyc;
        logic p;
        logic [15:0] c;
        logic [31:0] a, e, g;
        model((sel == 3) ? 3 : 1, cyc, p, c, a, e, g);
        run_scan(tag, sel, hold, cyc, p, c, a, e, g);
    endtask

    task automatic clean_ram();
        for (int i = 0; i < NWORDS; i++) ram_mem[i] = rom_mem[i];
    endtask

    typedef struct {
        int          bad0;
        int          bad1;
        logic [31:0] val0;
        logic [31:0] val1;
        int          exp_cnt;
        int          exp_first;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int ecnt, ecyc, wcnt;
        logic [31:0] ea, ee;

        vecs[0] = '{-1, -1, 32'h0, 32'h0, 0, -1};
        vecs[1] = '{16, -1, 32'hDEADBEEF, 32'h0, 1, 16};
        vecs[2] = '{3, 100, 32'h1234_5678 | 32'h8000_0000, 32'hA5A5_5A5A, 2, 3};
        vecs[3] = '{127, -1, 32'hFFFF_FFFF, 32'h0, 1, 127};
        vecs[4] = '{0, -1, 32'h8000_0000, 32'h0, 1, 0};
        vecs[5] = '{60, 61, 32'h9ABC_DEF0, 32'hDEADBEEF, 2, 60};

        // ROM words keep bit 31 clear so every table corruption value differs.
        for (int i = 0; i < NWORDS; i++) rom_mem[i] = $urandom & 32'h7FFF_FFFF;
        clean_ram();

        #12;
        chk("rst busy", 32'(busy1), 32'd0);
        chk("rst done", 32'(done1), 32'd0);
        chk("rst pass", 32'(pass1), 32'd0);
        chk("rst err_count", 32'(cnt1), 32'd0);
        chk("rst rom_addr", rom_addr1, 32'h0);
        chk("rst ram_addr", ram_addr1, RAM_BASE);
        chk("rst err_addr", eaddr1, 32'h0);
        chk("rst done0", 32'(done0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clean_ram();
            if (vecs[v].bad0 >= 0) ram_mem[vecs[v].bad0] = vecs[v].val0;
            if (vecs[v].bad1 >= 0) ram_mem[vecs[v].bad1] = vecs[v].val1;
            ecnt = (STOP && vecs[v].exp_cnt > 0) ? 1 : vecs[v].exp_cnt;
            ecyc = (STOP && vecs[v].exp_first >= 0) ? (vecs[v].exp_first + 1) * 2 : 256;
            ea = (vecs[v].exp_first >= 0) ? RAM_BASE + 32'(vecs[v].exp_first * 4) : 32'h0;
            ee = (vecs[v].exp_first >= 0) ? rom_mem[vecs[v].exp_first] : 32'h0;
            run_scan($sformatf("vec%0d", v), 1, 1'b0, ecyc, (vecs[v].exp_cnt == 0), 16'(ecnt), ea, ee,
                     (vecs[v].exp_first >= 0) ? vecs[v].val0 : 32'h0);
        end

        // Rescan from DONE with a clean image clears the previous errors.
        clean_ram();
        run_scan("rescan", 1, 1'b0, 256, 1'b1, 16'd0, 32'h0, 32'h0, 32'h0);

        // Start held high through most of the scan.
        ram_mem[40] = rom_mem[40] ^ 32'h0000_0100;
        run_model_scan("hold_start", 1, 1'b1);

        clean_ram();
        run_scan("lat3_clean", 3, 1'b0, 512, 1'b1, 16'd0, 32'h0, 32'h0, 32'h0);

        for (int r = 0; r < 8; r++) begin
            int nb;
            int idx;
            clean_ram();
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) begin
                idx = $urandom_range(0, NWORDS - 1);
                ram_mem[idx] = rom_mem[idx] ^ ($urandom | 32'h1);
            end
            run_model_scan($sformatf("rand%0d", r), (r % 2 == 0) ? 1 : 3, 1'b0);
        end

        // Reset in the middle of a scan that has already logged an error.
        clean_ram();
        ram_mem[10] = ~rom_mem[10];
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wcnt = 0;
        while (ram_addr1 != RAM_BASE + 32'd200 && wcnt < 400) begin
            @(posedge clk);
            #1;
            wcnt++;
        end
        chk("mid reached_word50", 32'(wcnt < 400), 32'd1);
        chk("mid err_logged", 32'(cnt1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid busy", 32'(busy1), 32'd0);
        chk("mid done", 32'(done1), 32'd0);
        chk("mid err_count", 32'(cnt1), 32'd0);
        chk("mid err_addr", eaddr1, 32'h0);
        chk("mid err_got", egot1, 32'h0);
        chk("mid rom_addr", rom_addr1, 32'h0);
        chk("mid ram_addr", ram_addr1, RAM_BASE);
        @(negedge clk);
        rst_n = 1'b1;
        clean_ram();
        run_scan("after_rst", 1, 1'b0, 256, 1'b1, 16'd0, 32'h0, 32'h0, 32'h0);

        // Empty image: done and pass right at the start edge.
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("empty done", 32'(done0), 32'd1);
        chk("empty pass", 32'(pass0), 32'd1);
        chk("empty busy", 32'(busy0), 32'd0);
        chk("empty err_count", 32'(cnt0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_readback_check.md
Name: mem_readback_check

Overview:
Post-boot read-back verifier; the reading counterpart of the boot ROM-to-RAM copier. After the copy finishes, it walks the ROM image and the RAM load region word by word and compares each pair. It reports pass/fail, a mismatch count and the first failing location. It sits between the boot ROM and data RAM read ports; the top level gates CPU release on its done/pass outputs.

Parameters:
ROM_BEGIN, 32'h00000000, first ROM byte address (word aligned)
ROM_END, 32'h00000200, ROM end byte address, exclusive; word count = (ROM_END-ROM_BEGIN)/4
RAM_BEGIN, `PC_START_ADDR, RAM byte address matching ROM_BEGIN
RD_LATENCY, 1, cycles from address presented to data valid on both ROM_Data and RAM_Data; legal 1..3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse/level; sampled in IDLE or DONE to begin a check
ROM_Addr  out  32  ROM read byte address (registered)
ROM_Data  in  32  ROM read data
RAM_Addr  out  32  RAM read byte address (registered)
RAM_Data  in  32  RAM read data
MemRW  out  1  RAM direction; constant `MemRW_L (read) from controller_code.vh
busy  out  1  check in progress
done  out  1  check complete; held until next start or reset
pass  out  1  valid when done=1; 1 = zero mismatches
err_count  out  16  mismatching words, saturates at 16'hFFFF
err_addr  out  32  RAM address of first mismatch
err_exp  out  32  ROM word at first mismatch
err_got  out  32  RAM word at first mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; ROM_Addr=ROM_BEGIN, RAM_Addr=RAM_BEGIN, busy=0, done=0, pass=0, err_count=0, err_addr/err_exp/err_got=0; MemRW=`MemRW_L always. A reset mid-check aborts immediately; no partial result is kept.
- States: IDLE, ADDR, WAIT, CMP, DONE.
- IDLE/DONE with start=1: load ROM_Addr=ROM_BEGIN, RAM_Addr=RAM_BEGIN, word counter=0, clear done/pass/err_*. Go to ADDR, busy=1. If the word count is 0, go directly to DONE with pass=1.
- ADDR: addresses stable for 1 cycle. Go to WAIT if RD_LATENCY>1, else CMP.
- WAIT: stay RD_LATENCY-1 cycles total, then go to CMP.
- CMP: compare ROM_Data with RAM_Data (full 32 bits).
  - On mismatch: err_count+1, saturating. If it is the first mismatch, capture err_addr=RAM_Addr, err_exp=ROM_Data, err_got=RAM_Data.
  - If this was the last word (counter = count-1), go to DONE. Otherwise advance both addresses by 4 (32-bit unsigned wrap), increment the counter, and go to ADDR.
- Per word: RD_LATENCY+1 cycles. Total from start edge to done rising = count*(RD_LATENCY+1) cycles.
- DONE: busy=0, done=1, pass=(err_count==0). Outputs held.
- start while busy is ignored.
- Counter width is 32 bits; address arithmetic is unsigned. RAM_Addr is never compared against ROM_END.

Optional Feature:
MEMCHK_STOP_ON_FAIL_EN
- Defined: a mismatch in CMP goes straight to DONE (pass=0, err_count=1) without advancing. The error fields hold the failing word.
- Undefined: the whole region is always scanned and err_count totals all mismatches.

Test Plan:
- Identical ROM/RAM models, 128 words, RD_LATENCY=1, start pulse -> done rises exactly 256 cycles after the start edge; pass=1, err_count=0, busy low with done.
- RAM word at RAM_BEGIN+0x40 corrupted to 32'hDEADBEEF -> pass=0, err_count=1, err_addr=RAM_BEGIN+0x40, err_got=32'hDEADBEEF, err_exp=ROM word 16.
- Mismatches at words 3 and 100 -> err_count=2, err_addr captures word 3 only. With MEMCHK_STOP_ON_FAIL_EN: done after 4*(RD_LATENCY+1) cycles, err_count=1.
- RD_LATENCY=3, models delay data 3 cycles -> no false mismatches; done after 512 cycles.
- rst_n asserted at word 50 -> all outputs return to reset values immediately. A new start then completes a full 128-word scan.
- start held high during the scan -> ignored. Start in DONE -> clears done/err_*, rescans; ROM_BEGIN=ROM_END -> done 1 cycle after start, pass=1.
